wg_done_arbiter: RTL and testbench

Collects workgroup-completion notifications from all per-CU handlers in the dispatcher and serialises them toward the GPU interface. Each CU handler holds a done request (valid + WG id) until acknowledged. This block grants one CU per cycle in round-robin order, buffers the completion in a small FIFO tagged with the CU id, and presents entries to the GPU interface over a valid/ack handshake.

---
 rtl/dispatcher_pkg.sv | 15 +
 rtl/wg_done_fifo.sv | 55 +++++
 rtl/wg_done_arbiter.sv | 113 +++++++++++
 tb/tb_wg_done_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared dispatcher definitions: default id widths and the layout of a
// workgroup-completion FIFO entry (WG id in the low bits, CU id above it).
package dispatcher_pkg;

  localparam int WG_ID_WIDTH = 6;
  localparam int CU_ID_WIDTH = 3;
  localparam int FIFO_DEPTH  = 4;

  localparam int ENTRY_WG_ID_L = 0;
  localparam int ENTRY_WG_ID_H = ENTRY_WG_ID_L + WG_ID_WIDTH - 1;
  localparam int ENTRY_CU_ID_L = ENTRY_WG_ID_H + 1;
  localparam int ENTRY_CU_ID_H = ENTRY_CU_ID_L + CU_ID_WIDTH - 1;
  localparam int ENTRY_WIDTH   = WG_ID_WIDTH + CU_ID_WIDTH;

endpackage

// File: rtl/wg_done_fifo.sv
// Small synchronous FIFO for completion entries. The head is shown
// combinationally and forced to zero while empty, so stale storage never
// leaks onto the outputs (including straight after reset).
module wg_done_fifo #(
  parameter int ENTRY_WIDTH     = dispatcher_pkg::ENTRY_WIDTH,
  parameter int FIFO_DEPTH      = dispatcher_pkg::FIFO_DEPTH,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [ENTRY_WIDTH-1:0] head
);

  logic [ENTRY_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_ADDR_WIDTH:0]   count_reg, count_next;
  logic                       push_en, pop_en;

  assign full    = (count_reg == (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (push_en && !pop_en) count_next = count_reg + 1'b1;
    else if (!push_en && pop_en) count_next = count_reg - 1'b1;
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and count registers; depth is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/wg_done_arbiter.sv
// Round-robin arbiter collecting per-CU workgroup-done requests into a
// completion FIFO that drains toward the GPU interface.
// Optional feature macro: WG_DONE_ARB_PERF_CNT_EN adds gpu_wg_done_count,
// a 32-bit wrapping count of entries popped by the GPU interface.
module wg_done_arbiter #(
  parameter int NUMBER_CU       = 8,
  parameter int CU_ID_WIDTH     = dispatcher_pkg::CU_ID_WIDTH,
  parameter int WG_ID_WIDTH     = dispatcher_pkg::WG_ID_WIDTH,
  parameter int FIFO_DEPTH      = dispatcher_pkg::FIFO_DEPTH,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUMBER_CU-1:0]             cu_wg_done_valid,
  input  logic [NUMBER_CU*WG_ID_WIDTH-1:0] cu_wg_done_wg_id,
  output logic [NUMBER_CU-1:0]             cu_wg_done_ack,
  output logic                             gpu_wg_done_valid,
  output logic [WG_ID_WIDTH-1:0]           gpu_wg_done_wg_id,
  output logic [CU_ID_WIDTH-1:0]           gpu_wg_done_cu_id,
  input  logic                             gpu_wg_done_ack
`ifdef WG_DONE_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                      gpu_wg_done_count
`endif
);

  // Entry layout follows the shared package: WG id low, CU id above it.
  localparam int ENTRY_WIDTH = WG_ID_WIDTH + CU_ID_WIDTH;

  logic [CU_ID_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CU_ID_WIDTH-1:0] grant_idx;
  logic                   grant_found;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [ENTRY_WIDTH-1:0] fifo_head;
  logic [WG_ID_WIDTH-1:0] cu_wg_id [NUMBER_CU];
  int                     scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_CU; gi++) begin : g_cu
      assign cu_wg_id[gi]       = cu_wg_done_wg_id[gi*WG_ID_WIDTH +: WG_ID_WIDTH];
      assign cu_wg_done_ack[gi] = push && (grant_idx == CU_ID_WIDTH'(gi));
    end
  endgenerate

  // First requesting CU at or after rr_ptr, wrapping explicitly at NUMBER_CU.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUMBER_CU; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= NUMBER_CU) scan_idx = scan_idx - NUMBER_CU;
      if (!grant_found && cu_wg_done_valid[scan_idx[CU_ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CU_ID_WIDTH-1:0];
      end
    end
  end

  // Grant needs room judged on the registered count only, so the GPU ack
  // never reaches the CU ack combinationally.
  assign push = grant_found && !fifo_full && !rst;
  assign pop  = gpu_wg_done_valid && gpu_wg_done_ack;

  // Pointer moves one past the granted CU; holds when nothing is granted.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (push) begin
      if (grant_idx == CU_ID_WIDTH'(NUMBER_CU - 1)) rr_ptr_next = '0;
      else rr_ptr_next = grant_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_reg <= '0;
    else     rr_ptr_reg <= rr_ptr_next;
  end

  wg_done_fifo #(
    .ENTRY_WIDTH     (ENTRY_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({grant_idx, cu_wg_id[grant_idx]}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign gpu_wg_done_valid = !fifo_empty;
  assign gpu_wg_done_wg_id = fifo_head[WG_ID_WIDTH-1:0];
  assign gpu_wg_done_cu_id = fifo_head[ENTRY_WIDTH-1 -: CU_ID_WIDTH];

`ifdef WG_DONE_ARB_PERF_CNT_EN
  logic [31:0] pop_count_reg;

  // Count every completion delivered to the GPU interface.
  always_ff @(posedge clk) begin
    if (rst)      pop_count_reg <= '0;
    else if (pop) pop_count_reg <= pop_count_reg + 32'd1;
  end

  assign gpu_wg_done_count = pop_count_reg;
`endif

endmodule

// File: tb/tb_wg_done_arbiter.sv
// Directed bench for wg_done_arbiter. Inputs change just after the falling
// edge and outputs are checked 1ns later, before the next rising edge.
module tb_wg_done_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cu_valid;
  logic [47:0] cu_wg;
  logic [7:0]  cu_ack;
  logic        gpu_valid;
  logic [5:0]  gpu_wg;
  logic [2:0]  gpu_cu;
  logic        gpu_ack;
`ifdef WG_DONE_ARB_PERF_CNT_EN
  logic [31:0] gpu_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wg_done_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .cu_wg_done_valid  (cu_valid),
    .cu_wg_done_wg_id  (cu_wg),
    .cu_wg_done_ack    (cu_ack),
    .gpu_wg_done_valid (gpu_valid),
    .gpu_wg_done_wg_id (gpu_wg),
    .gpu_wg_done_cu_id (gpu_cu),
    .gpu_wg_done_ack   (gpu_ack)
`ifdef WG_DONE_ARB_PERF_CNT_EN
    ,
    .gpu_wg_done_count (gpu_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One line per cycle: ack vector and head, checked against expectations.
  task automatic chk_cycle(input string tag, input logic [7:0] exp_ack,
                           input logic exp_v, input logic [2:0] exp_cu,
                           input logic [5:0] exp_wg);
    $display("%-10s cu_ack=%b gpu_v=%0d cu=%0d wg=0x%0h", tag, cu_ack, gpu_valid, gpu_cu, gpu_wg);
    chk({tag, ".ack"}, {24'd0, cu_ack}, {24'd0, exp_ack});
    chk({tag, ".gv"}, {31'd0, gpu_valid}, {31'd0, exp_v});
    if (exp_v) begin
      chk({tag, ".cu"}, {29'd0, gpu_cu}, {29'd0, exp_cu});
      chk({tag, ".wg"}, {26'd0, gpu_wg}, {26'd0, exp_wg});
    end
  endtask

  task automatic set_wg(input int i, input logic [5:0] v);
    cu_wg[i*6 +: 6] = v;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; cu_valid = 8'h00; cu_wg = '0; gpu_ack = 1'b0;
    step();
    // Reset: ack stays low even with a request present; outputs are zero.
    step(); cu_valid = 8'h08; set_wg(3, 6'h15); gpu_ack = 1'b1; settle();
    chk_cycle("rst", 8'h00, 1'b0, 3'd0, 6'd0);
    chk("rst.wg0", {26'd0, gpu_wg}, 32'd0);
    chk("rst.cu0", {29'd0, gpu_cu}, 32'd0);

    // Single request from CU 3.
    step(); rst = 1'b0; settle();
    chk_cycle("single0", 8'h08, 1'b0, 3'd0, 6'd0);
    step(); cu_valid = 8'h00; settle();
    chk_cycle("single1", 8'h00, 1'b1, 3'd3, 6'h15);
    step(); settle();
    chk_cycle("single2", 8'h00, 1'b0, 3'd0, 6'd0);

    // Reset to bring rr_ptr back to 0, then all eight CUs request at once.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    for (int i = 0; i < 8; i++) set_wg(i, 6'(6'h20 + i));
    cu_valid = 8'hFF; settle();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        step(); cu_valid[k-1] = 1'b0; settle();
      end
      chk_cycle($sformatf("all%0d", k), (k < 8) ? 8'(1 << k) : 8'h00,
                k > 0, 3'(k - 1), 6'(6'h20 + k - 1));
    end

    // Fairness and wrap: serve CU 6, then 7 and 1 request together.
    set_wg(6, 6'h06); set_wg(7, 6'h07); set_wg(1, 6'h01);
    step(); cu_valid = 8'h40; settle();
    chk_cycle("wrap0", 8'h40, 1'b0, 3'd0, 6'd0);
    step(); cu_valid = 8'h82; settle();
    chk_cycle("wrap1", 8'h80, 1'b1, 3'd6, 6'h06);
    step(); cu_valid = 8'h02; settle();
    chk_cycle("wrap2", 8'h02, 1'b1, 3'd7, 6'h07);
    step(); cu_valid = 8'h00; settle();
    chk_cycle("wrap3", 8'h00, 1'b1, 3'd1, 6'h01);
    step(); settle();
    chk_cycle("wrap4", 8'h00, 1'b0, 3'd0, 6'd0);

    // Full: GPU stalls, CUs 2..6 request; only four are accepted.
    for (int i = 2; i <= 6; i++) set_wg(i, 6'(6'h30 + i));
    step(); gpu_ack = 1'b0; cu_valid = 8'h7C; settle();
    chk_cycle("full0", 8'h04, 1'b0, 3'd0, 6'd0);
    step(); cu_valid = 8'h78; settle();
    chk_cycle("full1", 8'h08, 1'b1, 3'd2, 6'h32);
    step(); cu_valid = 8'h70; settle();
    chk_cycle("full2", 8'h10, 1'b1, 3'd2, 6'h32);
    step(); cu_valid = 8'h60; settle();
    chk_cycle("full3", 8'h20, 1'b1, 3'd2, 6'h32);
    step(); cu_valid = 8'h40; settle();
    chk_cycle("full4", 8'h00, 1'b1, 3'd2, 6'h32);
    step(); settle();
    chk_cycle("full5", 8'h00, 1'b1, 3'd2, 6'h32);
    // A pop while full does not open a push in the same cycle.
    step(); gpu_ack = 1'b1; settle();
    chk_cycle("full6", 8'h00, 1'b1, 3'd2, 6'h32);
    step(); gpu_ack = 1'b0; settle();
    chk_cycle("full7", 8'h40, 1'b1, 3'd3, 6'h33);

    // Drain to two entries, then push and pop together.
    step(); cu_valid = 8'h00; gpu_ack = 1'b1; settle();
    chk_cycle("pp0", 8'h00, 1'b1, 3'd3, 6'h33);
    step(); settle();
    chk_cycle("pp1", 8'h00, 1'b1, 3'd4, 6'h34);
    set_wg(0, 6'h3A);
    step(); cu_valid = 8'h01; settle();
    chk_cycle("pp2", 8'h01, 1'b1, 3'd5, 6'h35);
    // Two entries remain, so exactly two more acks fit.
    set_wg(1, 6'h11); set_wg(2, 6'h12); set_wg(3, 6'h13);
    step(); gpu_ack = 1'b0; cu_valid = 8'h0E; settle();
    chk_cycle("pp3", 8'h02, 1'b1, 3'd6, 6'h36);
    step(); cu_valid = 8'h0C; settle();
    chk_cycle("pp4", 8'h04, 1'b1, 3'd6, 6'h36);
    step(); cu_valid = 8'h08; gpu_ack = 1'b1; settle();
    chk_cycle("pp5", 8'h00, 1'b1, 3'd6, 6'h36);

    // Reset with three entries buffered and CU 3 still pending.
    step(); rst = 1'b1; gpu_ack = 1'b0; settle();
    chk_cycle("mrst0", 8'h00, 1'b1, 3'd0, 6'h3A);
    step(); rst = 1'b0; cu_valid = 8'h0A; settle();
    chk_cycle("mrst1", 8'h02, 1'b0, 3'd0, 6'd0);
    chk("mrst1.wg0", {26'd0, gpu_wg}, 32'd0);
`ifdef WG_DONE_ARB_PERF_CNT_EN
    chk("mrst1.cnt", gpu_count, 32'd0);
`endif
    step(); cu_valid = 8'h08; settle();
    chk_cycle("mrst2", 8'h08, 1'b1, 3'd1, 6'h11);
    step(); cu_valid = 8'h00; gpu_ack = 1'b1; settle();
    chk_cycle("mrst3", 8'h00, 1'b1, 3'd1, 6'h11);
    step(); settle();
    chk_cycle("mrst4", 8'h00, 1'b1, 3'd3, 6'h13);
`ifdef WG_DONE_ARB_PERF_CNT_EN
    chk("mrst4.cnt", gpu_count, 32'd1);
`endif
    step(); settle();
    chk_cycle("mrst5", 8'h00, 1'b0, 3'd0, 6'd0);
`ifdef WG_DONE_ARB_PERF_CNT_EN
    chk("mrst5.cnt", gpu_count, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
